// File: rtl/pkt_chan_queue_pkg.sv
// Shared helpers for the multi-channel packet queue: width derivation and
// drop-policy encodings.
package pkt_chan_queue_pkg;

    localparam bit POLICY_DROP_NEWEST = 1'b0;
    localparam bit POLICY_DROP_OLDEST = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Bits needed to name one of n channels.
    function automatic int ch_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int occ_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pkt_chan_queue_if.sv
// Bus bundle between the packet source / consumer and the channel queue.
interface pkt_chan_queue_if
    import pkt_chan_queue_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 6,
    parameter int DATA_W = 2,
    parameter int RCV_W  = 16,
    parameter int DROP_W = 11
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int OCC_W = occ_width(DEPTH);

    logic                       in_valid;
    logic [CH_W-1:0]            in_chan;
    logic [DATA_W-1:0]          in_data;
    logic [NUM_CH-1:0]          rd_sel;
    logic                       rd_valid;
    logic [DATA_W-1:0]          rd_data;
    logic [CH_W-1:0]            rd_chan;
    logic                       rd_err;
    logic [NUM_CH*OCC_W-1:0]    occ;
    logic [NUM_CH*RCV_W-1:0]    received;
    logic [NUM_CH*DROP_W-1:0]   dropped;

    modport master (
        output in_valid, in_chan, in_data, rd_sel,
        input  rd_valid, rd_data, rd_chan, rd_err, occ, received, dropped
    );

    modport slave (
        input  in_valid, in_chan, in_data, rd_sel,
        output rd_valid, rd_data, rd_chan, rd_err, occ, received, dropped
    );

endinterface

// File: rtl/pkt_chan_queue_fifo.sv
// One channel of the packet queue: shift-register storage with head at
// index 0, overflow drop policy and saturating received/dropped counters.
module pkt_chan_fifo
    import pkt_chan_queue_pkg::*;
#(
    parameter int DEPTH       = 6,
    parameter int DATA_W      = 2,
    parameter int RCV_W       = 16,
    parameter int DROP_W      = 11,
    parameter bit DROP_OLDEST = POLICY_DROP_OLDEST,
    localparam int OCC_W      = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] head,
    output logic [OCC_W-1:0]  occ,
    output logic [RCV_W-1:0]  received,
    output logic [DROP_W-1:0] dropped
);

    logic [DATA_W-1:0] mem      [DEPTH];
    logic [DATA_W-1:0] mem_next [DEPTH];
    logic              do_pop;
    logic              full;
    logic              do_shift;
    logic              do_write;
    logic              drop;
    logic [OCC_W-1:0]  wr_idx;
    logic [OCC_W-1:0]  occ_next;

    function automatic logic [RCV_W-1:0] sat_inc_rcv(input logic [RCV_W-1:0] v);
        return (&v) ? v : v + RCV_W'(1);
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    assign head = mem[0];

    // Decide shift/write/drop for this cycle; a pop on an empty queue is ignored
    // so a same-cycle push into an empty queue simply lands at index 0.
    always_comb begin
        do_pop   = pop && (occ != '0);
        full     = (occ == OCC_W'(DEPTH));
        do_shift = 1'b0;
        do_write = 1'b0;
        drop     = 1'b0;
        wr_idx   = occ;
        occ_next = occ;
        if (push && do_pop) begin
            do_shift = 1'b1;
            do_write = 1'b1;
            wr_idx   = occ - OCC_W'(1);
        end else if (push && full) begin
            drop = 1'b1;
            if (DROP_OLDEST) begin
                do_shift = 1'b1;
                do_write = 1'b1;
                wr_idx   = OCC_W'(DEPTH - 1);
            end
        end else if (push) begin
            do_write = 1'b1;
            occ_next = occ + OCC_W'(1);
        end else if (do_pop) begin
            do_shift = 1'b1;
            occ_next = occ - OCC_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) mem_next[i] = mem[i];
        if (do_shift) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_next[i] = mem[i + 1];
        end
        if (do_write) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == OCC_W'(i)) mem_next[i] = data;
            end
        end
    end

    // Storage, occupancy and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            occ      <= '0;
            received <= '0;
            dropped  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= mem_next[i];
            occ <= occ_next;
            if (push) received <= sat_inc_rcv(received);
            if (drop) dropped  <= sat_inc_drop(dropped);
        end
    end

endmodule

// File: rtl/pkt_chan_queue.sv
// Multi-channel packet queue top: write decoder, one-hot pop decoder with
// error pulse, head mux and registered read outputs.
module pkt_chan_queue
    import pkt_chan_queue_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 6,
    parameter int DATA_W      = 2,
    parameter int RCV_W       = 16,
    parameter int DROP_W      = 11,
    parameter bit DROP_OLDEST = POLICY_DROP_OLDEST
) (
    input  logic                clk,
    input  logic                rst_n,
    pkt_chan_queue_if.slave     bus
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [NUM_CH-1:0] push_vec;
    logic [NUM_CH-1:0] pop_vec;
    logic [NUM_CH-1:0] nonempty;
    logic              multi_sel;
    logic              pop_ok;
    logic [CH_W-1:0]   sel_idx;
    logic [DATA_W-1:0] head_arr [NUM_CH];
    logic [OCC_W-1:0]  occ_arr  [NUM_CH];
    logic [RCV_W-1:0]  rcv_arr  [NUM_CH];
    logic [DROP_W-1:0] drp_arr  [NUM_CH];

    logic              rd_valid_p1;
    logic              rd_err_p1;
    logic [DATA_W-1:0] rd_data_p1;
    logic [CH_W-1:0]   rd_chan_p1;

    // Steer the write strobe to the addressed channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) push_vec[i] = bus.in_valid && (bus.in_chan == CH_W'(i));
    end

    // Reject multi-bit selects, otherwise pop the selected channel.
    always_comb begin
        multi_sel = (bus.rd_sel & (bus.rd_sel - NUM_CH'(1))) != '0;
        pop_vec   = multi_sel ? '0 : bus.rd_sel;
        pop_ok    = !multi_sel && |(bus.rd_sel & nonempty);
        sel_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel[i]) sel_idx = CH_W'(i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pkt_chan_fifo #(
            .DEPTH       (DEPTH),
            .DATA_W      (DATA_W),
            .RCV_W       (RCV_W),
            .DROP_W      (DROP_W),
            .DROP_OLDEST (DROP_OLDEST)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push_vec[g]),
            .pop      (pop_vec[g]),
            .data     (bus.in_data),
            .head     (head_arr[g]),
            .occ      (occ_arr[g]),
            .received (rcv_arr[g]),
            .dropped  (drp_arr[g])
        );
        assign nonempty[g] = (occ_arr[g] != '0);
    end

    // Read result stage: valid/err pulse one cycle, data/chan hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_p1 <= 1'b0;
            rd_err_p1   <= 1'b0;
            rd_data_p1  <= '0;
            rd_chan_p1  <= '0;
        end else begin
            rd_valid_p1 <= pop_ok;
            rd_err_p1   <= multi_sel;
            if (pop_ok) begin
                rd_data_p1 <= head_arr[sel_idx];
                rd_chan_p1 <= sel_idx;
            end
        end
    end

    // Pack per-channel status onto the flat output buses.
    always_comb begin
        bus.occ      = '0;
        bus.received = '0;
        bus.dropped  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.occ[i*OCC_W +: OCC_W]       = occ_arr[i];
            bus.received[i*RCV_W +: RCV_W]  = rcv_arr[i];
            bus.dropped[i*DROP_W +: DROP_W] = drp_arr[i];
        end
    end

    assign bus.rd_valid = rd_valid_p1;
    assign bus.rd_err   = rd_err_p1;
    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_chan  = rd_chan_p1;

endmodule
